// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: shares the single L2 line port between the icache and
// dcache miss paths. A granted transaction runs until l2_resp and is never
// pre-empted, and every transaction is followed by at least one IDLE cycle.
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   defined   -> a tie in IDLE goes to the requester that did not own the
//                most recently completed transaction
//   undefined -> fixed priority; the dcache always wins a tie
//
// Handshake: a requester holds its read/write level from the cycle it raises
// it until the cycle in which it sees its x_resp. The arbiter registers the
// grant on the first edge that sees the request, drives the L2 request from
// the following cycle, and passes l2_resp back combinationally to the current
// owner only. Read data is not gated; x_resp alone qualifies it.

module l1_l2_arbiter (
  input  logic         clk,
  input  logic         reset,
  // icache miss path
  input  logic         i_read,
  input  logic [15:0]  i_addr,
  output logic [127:0] i_rdata,
  output logic         i_resp,
  // dcache miss / write-back path
  input  logic         d_read,
  input  logic         d_write,
  input  logic [15:0]  d_addr,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_resp,
  // shared L2 port
  output logic         l2_read,
  output logic         l2_write,
  output logic [15:0]  l2_addr,
  output logic [127:0] l2_wdata,
  input  logic [127:0] l2_rdata,
  input  logic         l2_resp,
  // one-hot owner: bit0 icache, bit1 dcache, 00 when idle
  output logic [1:0]   grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  // Current owner; grant is a one-to-one view of this register.
  state_t state;
  state_t state_next;

  // Owner of the most recently completed transaction: 0 icache, 1 dcache.
  logic last;

  logic want_i;
  logic want_d;
  logic serving;

  assign want_i  = i_read;
  assign want_d  = d_read | d_write;
  assign serving = (state == SERVE_I) || (state == SERVE_D);

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Record who finished last, on every SERVE_x -> IDLE transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b0;
    end else if (serving && l2_resp) begin
      last <= (state == SERVE_D);
    end
  end

  // Next-state: arbitrate only in IDLE, release only on l2_resp.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (want_i && want_d) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_next = last ? SERVE_I : SERVE_D;
`else
          state_next = SERVE_D;
`endif
        end else if (want_d) begin
          state_next = SERVE_D;
        end else if (want_i) begin
          state_next = SERVE_I;
        end
      end
      SERVE_I: begin
        if (l2_resp) state_next = IDLE;
      end
      SERVE_D: begin
        if (l2_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: steer the owner's request to L2 and L2's response to the owner.
  always_comb begin
    l2_read  = 1'b0;
    l2_write = 1'b0;
    l2_addr  = 16'h0000;
    l2_wdata = '0;
    grant    = 2'b00;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    unique case (state)
      SERVE_I: begin
        l2_read = 1'b1;
        l2_addr = i_addr;
        grant   = 2'b01;
        i_resp  = l2_resp;
      end
      SERVE_D: begin
        l2_read  = d_read;
        l2_write = d_write;
        l2_addr  = d_addr;
        l2_wdata = d_wdata;
        grant    = 2'b10;
        d_resp   = l2_resp;
      end
      default: begin
        // IDLE: nothing forwarded; l2_resp is ignored.
      end
    endcase
  end

  // Read data always mirrors L2; only x_resp says it is valid.
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter. Build with +define+ARB_ROUND_ROBIN_EN to
// check the round-robin tie-break; the default build checks fixed priority.
`timescale 1ns/1ps

module tb_l1_l2_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         i_read, d_read, d_write, l2_resp;
  logic [15:0]  i_addr, d_addr;
  logic [127:0] d_wdata, l2_rdata;
  logic [127:0] i_rdata, d_rdata, l2_wdata;
  logic         i_resp, d_resp, l2_read, l2_write;
  logic [15:0]  l2_addr;
  logic [1:0]   grant;

  l1_l2_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .i_read   (i_read),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_resp   (i_resp),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_resp   (d_resp),
    .l2_read  (l2_read),
    .l2_write (l2_write),
    .l2_addr  (l2_addr),
    .l2_wdata (l2_wdata),
    .l2_rdata (l2_rdata),
    .l2_resp  (l2_resp),
    .grant    (grant)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  localparam logic [127:0] DEAD_LINE = 128'h0000_0000_0000_0000_0000_0000_0000_DEAD;
  localparam logic [127:0] AAAA_LINE = {8{16'hAAAA}};
  localparam logic [127:0] BEEF_LINE = {8{16'hBEEF}};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge and settle just after it; inputs change in this window.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [1:0] exp_g;

  initial begin
    reset = 1'b1; i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = '0; l2_rdata = BEEF_LINE;
    tick(); tick();

    // ---- reset state ----
    chk("rst_grant", grant, 2'b00);
    chk("rst_l2_read", l2_read, 0);
    chk("rst_l2_write", l2_write, 0);
    chk("rst_l2_addr", l2_addr, 0);
    chk("rst_l2_wdata", l2_wdata, 0);
    chk("rst_i_rdata", i_rdata, BEEF_LINE);
    chk("rst_d_rdata", d_rdata, BEEF_LINE);
    reset = 1'b0;
    tick();
    chk("post_rst_grant", grant, 2'b00);

    // ---- single icache miss, L2 answers in the third cycle ----
    i_read = 1; i_addr = 16'h1230;
    settle();
    chk("i_no_comb_path", l2_read, 0);
    tick();
    chk("i_c1_grant", grant, 2'b01);
    chk("i_c1_l2_read", l2_read, 1);
    chk("i_c1_l2_addr", l2_addr, 16'h1230);
    chk("i_c1_l2_write", l2_write, 0);
    chk("i_c1_i_resp", i_resp, 0);
    tick();
    chk("i_c2_l2_read", l2_read, 1);
    tick();
    l2_resp = 1; l2_rdata = DEAD_LINE;
    settle();
    chk("i_c3_i_resp", i_resp, 1);
    chk("i_c3_i_rdata", i_rdata, DEAD_LINE);
    chk("i_c3_d_resp", d_resp, 0);
    tick();
    i_read = 0; l2_resp = 0;
    settle();
    chk("i_done_grant", grant, 2'b00);
    chk("i_done_i_resp", i_resp, 0);
    chk("i_done_l2_read", l2_read, 0);
    tick();

    // ---- dcache write-back with a 1-cycle L2 ----
    d_write = 1; d_addr = 16'h4560; d_wdata = AAAA_LINE;
    tick();
    chk("dw_grant", grant, 2'b10);
    chk("dw_l2_write", l2_write, 1);
    chk("dw_l2_read", l2_read, 0);
    chk("dw_l2_addr", l2_addr, 16'h4560);
    chk("dw_l2_wdata", l2_wdata, AAAA_LINE);
    chk("dw_d_resp_pre", d_resp, 0);
    l2_resp = 1;
    settle();
    chk("dw_d_resp", d_resp, 1);
    chk("dw_i_resp", i_resp, 0);
    tick();
    d_write = 0; l2_resp = 0;
    settle();
    chk("dw_done_grant", grant, 2'b00);
    chk("dw_done_l2_write", l2_write, 0);
    tick();

    // ---- stray l2_resp while IDLE ----
    l2_resp = 1;
    settle();
    chk("idle_resp_i", i_resp, 0);
    chk("idle_resp_d", d_resp, 0);
    tick();
    chk("idle_resp_grant", grant, 2'b00);
    l2_resp = 0;
    tick();

    // ---- simultaneous requests, held for four transactions ----
    reset = 1; tick(); reset = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
`else
    exp_q.push_back(2'b10); exp_q.push_back(2'b10);
    exp_q.push_back(2'b10); exp_q.push_back(2'b10);
`endif
    i_read = 1; i_addr = 16'h1110; d_read = 1; d_addr = 16'h2220;
    for (int t = 0; t < 4; t++) begin
      tick();
      exp_g = exp_q.pop_front();
      chk($sformatf("tie%0d_grant", t), grant, exp_g);
      chk($sformatf("tie%0d_addr", t), l2_addr, (exp_g == 2'b01) ? 16'h1110 : 16'h2220);
      l2_resp = 1;
      settle();
      chk($sformatf("tie%0d_i_resp", t), i_resp, exp_g[0]);
      chk($sformatf("tie%0d_d_resp", t), d_resp, exp_g[1]);
      tick();
      l2_resp = 0;
      if (t == 3) begin
        i_read = 0; d_read = 0;
      end
      settle();
      chk($sformatf("tie%0d_idle", t), grant, 2'b00);
    end
    tick();
    chk("tie_end_grant", grant, 2'b00);

    // ---- i_read rises while the dcache is being served ----
    d_read = 1; d_addr = 16'h4560;
    tick();
    chk("late_i_grant_d", grant, 2'b10);
    i_read = 1; i_addr = 16'h7770;
    tick();
    chk("late_i_still_d", grant, 2'b10);
    chk("late_i_l2_read", l2_read, 1);
    l2_resp = 1; l2_rdata = AAAA_LINE;
    settle();
    chk("late_i_d_resp", d_resp, 1);
    chk("late_i_d_rdata", d_rdata, AAAA_LINE);
    chk("late_i_i_resp", i_resp, 0);
    tick();
    d_read = 0; l2_resp = 0;
    settle();
    chk("late_i_idle", grant, 2'b00);
    tick();
    chk("late_i_grant_i", grant, 2'b01);
    chk("late_i_addr", l2_addr, 16'h7770);
    l2_resp = 1;
    settle();
    chk("late_i_i_resp2", i_resp, 1);
    tick();
    i_read = 0; l2_resp = 0;
    tick();

    // ---- reset in the middle of a dcache write-back ----
    d_write = 1; d_addr = 16'h9990; d_wdata = AAAA_LINE;
    tick();
    chk("rst_mid_l2_write", l2_write, 1);
    reset = 1;
    tick();
    reset = 0; l2_resp = 1;
    settle();
    chk("rst_mid_grant", grant, 2'b00);
    chk("rst_mid_l2_write0", l2_write, 0);
    chk("rst_mid_d_resp", d_resp, 0);
    d_write = 0; l2_resp = 0;
    tick();
    chk("rst_mid_final", grant, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
